// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source interrupt controller between raw button inputs and
// the cpu interrupt port. Each source is synchronised, optionally debounced,
// and edge-detected into a sticky pending bit. Pending bits are masked by
// ie and resolved by fixed priority (source 0 highest). A single registered
// irq is presented and retired by a one-cycle ack.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset, clears all state
//   in       in   [N_SRC] raw button levels, asynchronous to clock
//   ie       in   [N_SRC] per-source interrupt enable
//   ack      in   one-cycle acknowledge, honoured only while requesting
//   irq      out  registered interrupt request
//   vec      out  [clog2(N_SRC)] index of requested source, valid with irq
//   pending  out  [N_SRC] registered pending bits
//
// Build option: define IRQ_CTRL_DEBOUNCE_EN to insert a per-source debouncer
// (DB_CYCLES consecutive differing samples, 1..15) after the synchroniser.

module irq_ctrl #(
  parameter int unsigned N_SRC = 4
`ifdef IRQ_CTRL_DEBOUNCE_EN
  , parameter int unsigned DB_CYCLES = 4
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           in,
  input  logic [N_SRC-1:0]           ie,
  input  logic                       ack,
  output logic                       irq,
  output logic [$clog2(N_SRC)-1:0]   vec,
  output logic [N_SRC-1:0]           pending
);

  localparam int unsigned VW = $clog2(N_SRC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  logic [N_SRC-1:0] sync1_q, sync2_q;
  logic [N_SRC-1:0] deb;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [VW-1:0]    win;
  logic [VW-1:0]    vec_q, vec_d;
  logic             irq_q, irq_d;
  state_e           state_q, state_d;

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

`ifdef IRQ_CTRL_DEBOUNCE_EN
  localparam int unsigned CW = 4;

  logic [N_SRC-1:0]          deb_q, deb_d;
  logic [N_SRC-1:0][CW-1:0]  cnt_q, cnt_d;

  // Counter tracks how long the synchronised level has disagreed with the
  // accepted level; any agreement restarts it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb = deb_q;
`else
  assign deb = sync2_q;
`endif

  // Edge detect and eligibility
  assign rise = deb & ~prev_q;
  assign elig = pending_q & ie;

  // Fixed priority: lowest set index wins
  always_comb begin
    win = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) win = VW'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|elig) state_d = ST_REQ;
      ST_REQ: begin
        if (ack)              state_d = ST_GAP;
        else if (!ie[vec_q])  state_d = ST_IDLE;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; a new rise beats a same-cycle ack clear
  always_comb begin
    vec_d = vec_q;
    clr   = '0;
    if (state_q == ST_IDLE && |elig) vec_d = win;
    if (state_q == ST_REQ && ack)    clr[vec_q] = 1'b1;
    irq_d     = (state_d == ST_REQ);
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      pending_q <= '0;
      vec_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= deb;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      irq_q     <= irq_d;
    end
  end

  assign irq     = irq_q;
  assign vec     = vec_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomised
// run, all compared against a cycle-level behavioural model.

module tb_irq_ctrl;

  localparam int unsigned N = 4;
`ifdef IRQ_CTRL_DEBOUNCE_EN
  localparam int unsigned DB = 4;
`else
  localparam int unsigned DB = 0;
`endif
  // Edges from an in change to pending set, and to irq high
  localparam int P_LAT = 3 + int'(DB);
  localparam int I_LAT = 4 + int'(DB);

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [3:0] ie;
  logic       ack;
  logic       irq;
  logic [1:0] vec;
  logic [3:0] pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  irq_ctrl #(
    .N_SRC(N)
`ifdef IRQ_CTRL_DEBOUNCE_EN
    , .DB_CYCLES(DB)
`endif
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in),
    .ie      (ie),
    .ack     (ack),
    .irq     (irq),
    .vec     (vec),
    .pending (pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 = no request, 1 = requesting, 2 = one-cycle quiet after ack
  logic [3:0] m_sync1, m_s, m_d, m_prev, m_pend;
  logic [1:0] m_vec;
  int         m_mode;
  logic [3:0] mt_dnow, mt_rise, mt_clr, mt_elig;
  int         mt_next;
  bit         mt_found;
`ifdef IRQ_CTRL_DEBOUNCE_EN
  logic [3:0] m_hist[$];
  bit         mt_all;
`endif

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sync1 = '0; m_s = '0; m_d = '0; m_prev = '0; m_pend = '0;
      m_vec = '0; m_mode = 0;
`ifdef IRQ_CTRL_DEBOUNCE_EN
      m_hist.delete();
`endif
    end else begin
`ifdef IRQ_CTRL_DEBOUNCE_EN
      mt_dnow = m_d;
`else
      mt_dnow = m_s;
`endif
      mt_rise = mt_dnow & ~m_prev;
      mt_elig = m_pend & ie;
      mt_clr  = '0;
      mt_next = m_mode;
      if (m_mode == 1) begin
        if (ack) begin
          mt_clr[m_vec] = 1'b1;
          mt_next = 2;
        end else if (!ie[m_vec]) begin
          mt_next = 0;
        end
      end else if (m_mode == 2) begin
        mt_next = 0;
      end else if (mt_elig != 4'h0) begin
        mt_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (mt_elig[i] && !mt_found) begin
            m_vec = 2'(i);
            mt_found = 1'b1;
          end
        end
        mt_next = 1;
      end
      m_pend = (m_pend & ~mt_clr) | mt_rise;
      m_prev = mt_dnow;
`ifdef IRQ_CTRL_DEBOUNCE_EN
      // Accept a new level once the last DB samples all disagreed with it
      m_hist.push_back(m_s);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      if (m_hist.size() == DB) begin
        for (int b = 0; b < 4; b++) begin
          mt_all = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][b] == m_d[b]) mt_all = 1'b0;
          if (mt_all) m_d[b] = ~m_d[b];
        end
      end
`endif
      m_s     = m_sync1;
      m_sync1 = in;
      m_mode  = mt_next;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check_eq("model_irq", 32'(irq), 32'(m_mode == 1));
      check_eq("model_pending", 32'(pending), 32'(m_pend));
      if (m_mode == 1) check_eq("model_vec", 32'(vec), 32'(m_vec));
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    in = '0; ie = '0; ack = 1'b0;
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int k = 0;
    while (irq !== 1'b1 && k < budget) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(irq), 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; in = 4'hF; ie = 4'h0; ack = 1'b0;
    #1 reset = 1'b1;

    // Reset with all buttons held high
    cyc(2);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_vec", 32'(vec), 32'd0);
    check_eq("rst_pend", 32'(pending), 32'h0);
    chk_en = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(P_LAT);
    check_eq("rst_pend_after", 32'(pending), 32'hF);
    check_eq("rst_irq_masked", 32'(irq), 32'd0);

    // Single event on source 0
    do_reset();
    ie = 4'h1; in = 4'h1;
    cyc(I_LAT - 1);
    check_eq("single_early", 32'(irq), 32'd0);
    cyc(1);
    check_eq("single_irq", 32'(irq), 32'd1);
    check_eq("single_vec", 32'(vec), 32'd0);
    pulse_ack();
    check_eq("single_ack_irq", 32'(irq), 32'd0);
    check_eq("single_ack_pend", 32'(pending), 32'h0);
    cyc(10 - I_LAT - 1);
    in = 4'h0;
    cyc(10 + int'(DB));
    check_eq("single_no_second", 32'(irq), 32'd0);

    // Priority, chaining, no pre-emption
    do_reset();
    ie = 4'hF; in = 4'b1010;
    wait_irq("prio_first_req", I_LAT + 2);
    check_eq("prio_first_vec", 32'(vec), 32'd1);
    in = 4'b1011;
    cyc(P_LAT + 1);
    check_eq("prio_hold_irq", 32'(irq), 32'd1);
    check_eq("prio_no_preempt", 32'(vec), 32'd1);
    check_eq("prio_pend3", 32'(pending), 32'hB);
    pulse_ack();
    check_eq("prio_gap", 32'(irq), 32'd0);
    check_eq("prio_pend_clr1", 32'(pending), 32'h9);
    cyc(1);
    check_eq("prio_idle", 32'(irq), 32'd0);
    cyc(1);
    check_eq("prio_second_irq", 32'(irq), 32'd1);
    check_eq("prio_second_vec", 32'(vec), 32'd0);
    pulse_ack();
    cyc(2);
    check_eq("prio_third_irq", 32'(irq), 32'd1);
    check_eq("prio_third_vec", 32'(vec), 32'd3);
    pulse_ack();
    check_eq("prio_all_clear", 32'(pending), 32'h0);
    in = 4'h0;
    cyc(P_LAT + 2);

    // Masking and withdrawal
    do_reset();
    in = 4'h4;
    cyc(P_LAT + 2);
    check_eq("mask_pend", 32'(pending), 32'h4);
    check_eq("mask_irq", 32'(irq), 32'd0);
    ie = 4'h4;
    cyc(1);
    check_eq("mask_en_irq", 32'(irq), 32'd1);
    check_eq("mask_en_vec", 32'(vec), 32'd2);
    ie = 4'h0;
    cyc(1);
    check_eq("withdraw_irq", 32'(irq), 32'd0);
    check_eq("withdraw_pend", 32'(pending), 32'h4);

    // Same-edge set and clear on source 0: set wins
    do_reset();
    ie = 4'h1; in = 4'h1;
    wait_irq("coll_req", I_LAT + 2);
    in = 4'h0;
    cyc(P_LAT + 2);
    check_eq("coll_still_req", 32'(irq), 32'd1);
    in = 4'h1;
    cyc(P_LAT - 1);
    pulse_ack();
    check_eq("coll_set_wins", 32'(pending), 32'h1);
    check_eq("coll_gap", 32'(irq), 32'd0);
    cyc(1);
    check_eq("coll_idle", 32'(irq), 32'd0);
    cyc(1);
    check_eq("coll_reassert", 32'(irq), 32'd1);
    check_eq("coll_vec", 32'(vec), 32'd0);

`ifdef IRQ_CTRL_DEBOUNCE_EN
    // Debounce: short glitch filtered, longer pulse accepted
    do_reset();
    in = 4'h1;
    cyc(3);
    in = 4'h0;
    cyc(15);
    check_eq("deb_glitch", 32'(pending), 32'h0);
    in = 4'h1;
    cyc(6);
    in = 4'h0;
    cyc(15);
    check_eq("deb_pulse", 32'(pending), 32'h1);
`endif

    // Randomised traffic with one mid-run reset
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      @(negedge clock);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) in[b] = ~in[b];
      end
      if ($urandom_range(0, 19) == 0) ie = 4'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      if (c == 1200) #1 reset = 1'b1;
      if (c == 1203) reset = 1'b0;
    end
    ack = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Four-source interrupt controller that sits between the raw button inputs and the `cpu` interrupt port, in place of the button chain's combined `irq` path. Each source is synchronised, optionally debounced and edge-detected into a sticky pending bit. Pending bits are masked by the CPU's per-source `ie`, then resolved by fixed priority, with source 0 highest. A single `irq` request is presented to the CPU and retired by its `ack` pulse.

## Interface
- `N_SRC`, 4: number of sources; fixed at 4 in this design, widths below assume 4.
- `DB_CYCLES`, 4: consecutive identical samples needed to accept a level change. Used only with `IRQ_CTRL_DEBOUNCE_EN`; legal range 1–15.

Ports:
- `clock`, input, 1: system clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `in`, input, 4: raw button levels, asynchronous to `clock`.
- `ie`, input, 4: per-source interrupt enable from `cpu`.
- `ack`, input, 1: one-cycle acknowledge pulse from `cpu`.
- `irq`, output, 1: registered interrupt request to `cpu`.
- `vec`, output, 2: index of the source being requested; valid while `irq`=1.
- `pending`, output, 4: registered pending bits, for status readback.

## Operation
- Reset values:
  - `irq`=0, `vec`=0, `pending`=0.
  - Synchroniser, edge, and debounce registers all 0.
  - FSM in IDLE.
- Input path, per source:
  - 2-FF synchroniser, giving `s`.
  - Optional debouncer, giving `d`; equal to `s` when the debouncer is compiled out.
  - `prev` register holds the previous `d`.
  - `rise = d & ~prev`.
- Pending bits:
  - `rise[i]` sets `pending[i]`.
  - `pending[i]` clears when the FSM takes `ack` in REQ with `vec`=i.
  - If set and clear happen in the same cycle, set wins.
  - A rise while `pending[i]` is already 1 is coalesced; no count is kept.
- Eligibility: `elig = pending & ie`. Winner is the lowest set index of `elig`.
- FSM states:
  - IDLE: `irq`=0. If `elig`≠0, latch the winner into `vec` and go to REQ.
  - REQ: `irq`=1 and `vec` holds steady.
    - `ack`=1: clear `pending[vec]` and go to GAP.
    - Else if `ie[vec]`=0 (withdrawn): go to IDLE with the pending bit kept.
    - A higher-priority arrival does not pre-empt the latched `vec`.
  - GAP: `irq`=0 for exactly one cycle, then IDLE.
- `ack` outside REQ is ignored.
- `ie` changes affect only new winner selection and withdrawal; pending bits still latch while disabled.

## Timing
- `irq` is registered and driven from FSM state only; it has no combinational path from any input.
- Latency without debounce: `in` rises before edge 0.
  - `s` is valid after edge 1.
  - `prev` compare, `rise`, and `pending` set at edge 2.
  - REQ entered and `irq`=1 after edge 3.
- Debounce adds `DB_CYCLES` edges of latency.
- `ack` sampled at edge k in REQ:
  - `irq`=0 and `pending[vec]`=0 after edge k.
  - The next `irq` is possible no earlier than after edge k+2, because of GAP.
- Back-to-back service: minimum 3 cycles between `irq` rising edges.
- Reset asserted mid-operation clears everything at once, including an asserted `irq`. The first `irq` after deassertion obeys the same latency from a fresh `in` rise. A source held high through reset is seen as a rise once `prev`=0 propagates.

## Configuration
- `IRQ_CTRL_DEBOUNCE_EN` defined:
  - Per-source 4-bit counter.
  - The counter resets to 0 whenever `s`≠`d`'s candidate value changes.
  - `d` updates to `s` once `s`≠`d` has held for `DB_CYCLES` consecutive cycles.
  - Glitches shorter than `DB_CYCLES` cycles produce no rise.
- Not defined: `d`=`s`; no counters are instantiated; every synchronised rise counts.

## Test plan
- Reset check: assert `reset` with `in`=4'hF. Outputs stay 0 throughout reset; after release, `pending`=4'hF within 3 edges.
- Single event: `ie`=4'h1, pulse `in[0]` high for 10 cycles. Required: `irq`=1 after edge 3 (debounce off), `vec`=0, `ack` pulse gives `irq`=0 and `pending`=0 on the next edge, no second `irq`.
- Priority and chaining: `ie`=4'hF, raise `in[3]` and `in[1]` in the same cycle.
  - Required: `vec`=1 first; after `ack`, one GAP cycle, then `vec`=3.
  - An `in[0]` rise during the `vec`=1 REQ does not change `vec`. It is served before 3.
- Masking and withdrawal: `ie`=0, raise `in[2]`. Required: `pending`=4'h4, `irq`=0. Set `ie[2]`=1; `irq`=1 with `vec`=2. Clear `ie[2]` before `ack`; `irq` drops next edge and `pending` is still 4'h4.
- Set/clear collision: arrange a fresh `rise[0]` on the same edge as `ack` for `vec`=0. Required: `pending[0]`=1 afterwards, `irq` reasserts after GAP.
- Debounce, with `IRQ_CTRL_DEBOUNCE_EN` defined and `DB_CYCLES`=4: a 3-cycle `in[0]` glitch gives no `pending` change; a 6-cycle pulse gives `pending[0]`=1.
